// File: rtl/debug_pkg.sv
// Shared constants for the debug unit: frame geometry, command bytes and the
// receiver state encoding.
package debug_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_FAST = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIV clocks,
// DIV = round(CLK_FREQ / (BAUD * OVERSAMPLE)). Shared with the transmitter.
module baud_tick_gen #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 19_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Free-running divider, wraps from DIV-1 back to 0.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    // Divider register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 16x oversampled. Delivers each good byte with a one-cycle
// done strobe; a low stop bit gives a one-cycle frame-error strobe and parks
// the FSM in BREAK until the line returns high.
module uart_rx_oversampled #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 19_200,
    parameter int unsigned DATA_BITS  = debug_pkg::DATA_BITS,
    parameter int unsigned OVERSAMPLE = debug_pkg::OVERSAMPLE,
    parameter int unsigned STOP_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 os_rx_done,
    output logic                 os_frame_err
);
    import debug_pkg::*;

    localparam int unsigned SMAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
    localparam int unsigned SCW  = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int unsigned NCW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SCW-1:0] S_HALF = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] S_FULL = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] S_STOP = SCW'(STOP_TICKS - 1);
    localparam logic [NCW-1:0] N_LAST = NCW'(DATA_BITS - 1);

    logic                 tick;
    logic                 rx_meta_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [SCW-1:0]       s_cnt_q, s_cnt_d;
    logic [NCW-1:0]       n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM: start qualification at mid start bit, mid-bit data sampling, stop check.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt_q == S_HALF) begin
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt_q == S_FULL) begin
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == N_LAST) state_d = ST_STOP;
                        else                   n_cnt_d = n_cnt_q + 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_cnt_q == S_STOP) begin
                        if (rx_s_q) begin
                            data_d  = shreg_q;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_rx_data    = data_q;
    assign os_rx_done   = done_q;
    assign os_frame_err = ferr_q;

endmodule
